// File: rtl/rob_commit.sv
// Circular reorder buffer: allocates tags at issue, captures writeback results,
// retires in program order onto the regfile write port and flushes on a mispredicted head branch.
module rob_commit #(
  parameter int ROB_WIDTH_BIT = 3,
  parameter int REG_ID_BIT    = 5
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_en,
  input  logic [REG_ID_BIT-1:0]    issue_reg,
  input  logic                     issue_is_br,
  output logic                     rob_full,
  output logic [ROB_WIDTH_BIT-1:0] tail_id,
  input  logic                     wb_en,
  input  logic [ROB_WIDTH_BIT-1:0] wb_id,
  input  logic [31:0]              wb_value,
  input  logic                     wb_mispredict,
  input  logic [31:0]              wb_target,
  input  logic [ROB_WIDTH_BIT-1:0] q1_id,
  input  logic [ROB_WIDTH_BIT-1:0] q2_id,
  output logic                     q1_ready,
  output logic                     q2_ready,
  output logic [31:0]              q1_value,
  output logic [31:0]              q2_value,
  output logic                     commit_en,
  output logic [REG_ID_BIT-1:0]    commit_reg,
  output logic [ROB_WIDTH_BIT-1:0] commit_id,
  output logic [31:0]              commit_value,
  output logic                     flush_out,
  output logic [31:0]              flush_pc
);

  localparam int DEPTH = 1 << ROB_WIDTH_BIT;
  localparam logic [ROB_WIDTH_BIT:0]   DEPTH_CNT = DEPTH[ROB_WIDTH_BIT:0];
  localparam logic [ROB_WIDTH_BIT:0]   ONE_CNT   = 1;
  localparam logic [ROB_WIDTH_BIT-1:0] ONE_ID    = 1;

  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      ready;
  logic [DEPTH-1:0]      is_br;
  logic [DEPTH-1:0]      mispred;
  logic [REG_ID_BIT-1:0] dest   [DEPTH];
  logic [31:0]           value  [DEPTH];
  logic [31:0]           target [DEPTH];

  logic [ROB_WIDTH_BIT-1:0] head;
  logic [ROB_WIDTH_BIT-1:0] tail;
  logic [ROB_WIDTH_BIT:0]   count;

  logic do_issue;
  logic do_wb;
  logic do_commit;
  logic do_flush;

  assign rob_full  = (count == DEPTH_CNT);
  assign tail_id   = tail;
  assign do_issue  = issue_en && !rob_full;
  assign do_wb     = wb_en && busy[wb_id];
  assign do_commit = busy[head] && ready[head];
  assign do_flush  = do_commit && mispred[head];

  // The writeback bus is forwarded ahead of stored results so decode sees it in the same cycle.
  always_comb begin
    q1_ready = (busy[q1_id] && ready[q1_id]) || (wb_en && (wb_id == q1_id));
    q2_ready = (busy[q2_id] && ready[q2_id]) || (wb_en && (wb_id == q2_id));
    q1_value = '0;
    q2_value = '0;
    if (wb_en && (wb_id == q1_id))       q1_value = wb_value;
    else if (busy[q1_id] && ready[q1_id]) q1_value = value[q1_id];
    if (wb_en && (wb_id == q2_id))       q2_value = wb_value;
    else if (busy[q2_id] && ready[q2_id]) q2_value = value[q2_id];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy         <= '0;
      ready        <= '0;
      is_br        <= '0;
      mispred      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest[i]   <= '0;
        value[i]  <= '0;
        target[i] <= '0;
      end
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_en    <= 1'b0;
      commit_reg   <= '0;
      commit_id    <= '0;
      commit_value <= '0;
      flush_out    <= 1'b0;
      flush_pc     <= '0;
    end else if (!rdy_in) begin
      commit_en <= 1'b0;
      flush_out <= 1'b0;
    end else begin
      commit_en <= do_commit;
      flush_out <= do_flush;
      if (do_commit) begin
        commit_reg   <= dest[head];
        commit_id    <= head;
        commit_value <= value[head];
      end
      if (do_flush) begin
        // The branch itself still retires above; everything younger is dropped.
        flush_pc <= target[head];
        busy     <= '0;
        ready    <= '0;
        is_br    <= '0;
        mispred  <= '0;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (do_issue) begin
          busy[tail]    <= 1'b1;
          ready[tail]   <= 1'b0;
          dest[tail]    <= issue_reg;
          is_br[tail]   <= issue_is_br;
          mispred[tail] <= 1'b0;
          tail          <= tail + ONE_ID;
        end
        if (do_wb) begin
          ready[wb_id]   <= 1'b1;
          value[wb_id]   <= wb_value;
          mispred[wb_id] <= wb_mispredict && is_br[wb_id];
          target[wb_id]  <= wb_target;
        end
        if (do_commit) begin
          busy[head]    <= 1'b0;
          ready[head]   <= 1'b0;
          mispred[head] <= 1'b0;
          head          <= head + ONE_ID;
        end
        if (do_issue && !do_commit)      count <= count + ONE_CNT;
        else if (!do_issue && do_commit) count <= count - ONE_CNT;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: issue/writeback/commit ordering, full, flush, forwarding, pause, wrap, reset.
module tb_rob_commit;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_en, issue_is_br;
  logic [4:0]  issue_reg;
  logic        rob_full;
  logic [2:0]  tail_id;
  logic        wb_en, wb_mispredict;
  logic [2:0]  wb_id;
  logic [31:0] wb_value, wb_target;
  logic [2:0]  q1_id, q2_id;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_value, q2_value;
  logic        commit_en;
  logic [4:0]  commit_reg;
  logic [2:0]  commit_id;
  logic [31:0] commit_value;
  logic        flush_out;
  logic [31:0] flush_pc;

  int checks = 0;
  int failures = 0;

  rob_commit #(.ROB_WIDTH_BIT(3), .REG_ID_BIT(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_en(issue_en), .issue_reg(issue_reg), .issue_is_br(issue_is_br),
    .rob_full(rob_full), .tail_id(tail_id),
    .wb_en(wb_en), .wb_id(wb_id), .wb_value(wb_value),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_en(commit_en), .commit_reg(commit_reg), .commit_id(commit_id),
    .commit_value(commit_value), .flush_out(flush_out), .flush_pc(flush_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1;
    issue_en = 1'b0; issue_reg = '0; issue_is_br = 1'b0;
    wb_en = 1'b0; wb_id = '0; wb_value = '0; wb_mispredict = 1'b0; wb_target = '0;
    q1_id = '0; q2_id = '0;
    tick(); tick();
    check("rst_commit_en", 64'(commit_en), 64'(0));
    check("rst_flush_out", 64'(flush_out), 64'(0));
    check("rst_rob_full", 64'(rob_full), 64'(0));
    check("rst_tail_id", 64'(tail_id), 64'(0));
    check("rst_commit_value", 64'(commit_value), 64'(0));
    check("rst_flush_pc", 64'(flush_pc), 64'(0));
    rst_in = 1'b1;

    // Single issue, writeback, commit one cycle after writeback
    issue_en = 1'b1; issue_reg = 5'd5;
    tick();
    issue_en = 1'b0;
    check("t1_tail_id", 64'(tail_id), 64'(1));
    wb_en = 1'b1; wb_id = 3'd0; wb_value = 32'hDEAD;
    tick();
    wb_en = 1'b0;
    check("t1_no_commit_same_edge", 64'(commit_en), 64'(0));
    tick();
    check("t1_commit_en", 64'(commit_en), 64'(1));
    check("t1_commit_reg", 64'(commit_reg), 64'(5));
    check("t1_commit_id", 64'(commit_id), 64'(0));
    check("t1_commit_value", 64'(commit_value), 64'(32'hDEAD));
    tick();
    check("t1_commit_pulse", 64'(commit_en), 64'(0));
    check("t1_commit_reg_hold", 64'(commit_reg), 64'(5));

    // Fill, overflow attempt, out-of-order writeback, in-order commit
    do_reset();
    issue_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue_reg = 5'(10 + i);
      tick();
      if (i == 6) check("t2_not_full_at_7", 64'(rob_full), 64'(0));
    end
    check("t2_full", 64'(rob_full), 64'(1));
    check("t2_tail_wrap", 64'(tail_id), 64'(0));
    issue_reg = 5'd31;
    tick();
    issue_en = 1'b0;
    check("t2_overflow_tail", 64'(tail_id), 64'(0));
    check("t2_overflow_full", 64'(rob_full), 64'(1));
    wb_en = 1'b1; wb_id = 3'd3; wb_value = 32'h103;
    tick();
    check("t2_wb3_no_commit", 64'(commit_en), 64'(0));
    wb_id = 3'd1; wb_value = 32'h101;
    tick();
    check("t2_wb1_no_commit", 64'(commit_en), 64'(0));
    wb_id = 3'd0; wb_value = 32'h100;
    tick();
    check("t2_wb0_no_commit", 64'(commit_en), 64'(0));
    wb_id = 3'd2; wb_value = 32'h102;
    tick();
    wb_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t2_commit_en", 64'(commit_en), 64'(1));
      check("t2_commit_id", 64'(commit_id), 64'(k));
      check("t2_commit_reg", 64'(commit_reg), 64'(10 + k));
      check("t2_commit_value", 64'(commit_value), 64'(32'h100 + k));
      tick();
    end
    check("t2_stall_at_4", 64'(commit_en), 64'(0));
    check("t2_not_full", 64'(rob_full), 64'(0));

    // Mispredicted branch at head
    do_reset();
    issue_en = 1'b1; issue_is_br = 1'b1; issue_reg = 5'd1;
    tick();
    issue_is_br = 1'b0; issue_reg = 5'd7;
    tick();
    issue_en = 1'b0;
    wb_en = 1'b1; wb_id = 3'd0; wb_value = 32'h44; wb_mispredict = 1'b1; wb_target = 32'h1000;
    tick();
    check("t3_no_flush_yet", 64'(flush_out), 64'(0));
    wb_id = 3'd1; wb_value = 32'h77; wb_mispredict = 1'b0; wb_target = 32'h0;
    issue_en = 1'b1; issue_reg = 5'd9;
    tick();
    wb_en = 1'b0; issue_en = 1'b0;
    check("t3_flush_out", 64'(flush_out), 64'(1));
    check("t3_flush_pc", 64'(flush_pc), 64'(32'h1000));
    check("t3_link_commit_en", 64'(commit_en), 64'(1));
    check("t3_link_commit_reg", 64'(commit_reg), 64'(1));
    check("t3_link_commit_value", 64'(commit_value), 64'(32'h44));
    check("t3_tail_reset", 64'(tail_id), 64'(0));
    q1_id = 3'd1;
    #1;
    check("t3_id1_discarded", 64'(q1_ready), 64'(0));
    tick();
    check("t3_flush_pulse", 64'(flush_out), 64'(0));
    check("t3_no_commit_after", 64'(commit_en), 64'(0));
    tick();
    check("t3_id1_never_commits", 64'(commit_en), 64'(0));
    check("t3_empty", 64'(rob_full), 64'(0));

    // Operand queries with same-cycle forwarding
    issue_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_reg = 5'(1 + i);
      tick();
    end
    issue_en = 1'b0;
    wb_en = 1'b1; wb_id = 3'd2; wb_value = 32'hABCD;
    q1_id = 3'd2; q2_id = 3'd1;
    #1;
    check("t4_fwd_ready", 64'(q1_ready), 64'(1));
    check("t4_fwd_value", 64'(q1_value), 64'(32'hABCD));
    check("t4_unwritten_ready", 64'(q2_ready), 64'(0));
    check("t4_unwritten_value", 64'(q2_value), 64'(0));
    tick();
    wb_en = 1'b0;
    #1;
    check("t4_stored_ready", 64'(q1_ready), 64'(1));
    check("t4_stored_value", 64'(q1_value), 64'(32'hABCD));
    check("t4_no_commit", 64'(commit_en), 64'(0));

    // Pause with a commit pending
    wb_en = 1'b1; wb_id = 3'd0; wb_value = 32'h11;
    tick();
    wb_en = 1'b0;
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_paused_no_commit", 64'(commit_en), 64'(0));
    end
    check("t5_paused_tail", 64'(tail_id), 64'(3));
    rdy_in = 1'b1;
    tick();
    check("t5_resume_commit_en", 64'(commit_en), 64'(1));
    check("t5_resume_commit_id", 64'(commit_id), 64'(0));
    check("t5_resume_commit_value", 64'(commit_value), 64'(32'h11));
    tick();
    check("t5_single_commit", 64'(commit_en), 64'(0));

    // Full-throughput stream with tag wrap
    do_reset();
    for (int i = 0; i < 22; i++) begin
      issue_en  = (i < 20);
      issue_reg = 5'(i % 31 + 1);
      wb_en     = (i >= 1 && i <= 20);
      wb_id     = 3'((i + 7) % 8);
      wb_value  = 32'h1000 + 32'(i) - 32'd1;
      tick();
      if (i >= 2) begin
        check("t6_commit_en", 64'(commit_en), 64'(1));
        check("t6_commit_id", 64'(commit_id), 64'((i - 2) % 8));
        check("t6_commit_reg", 64'(commit_reg), 64'((i - 2) % 31 + 1));
        check("t6_commit_value", 64'(commit_value), 64'(32'h1000 + 32'(i - 2)));
      end else begin
        check("t6_fill_no_commit", 64'(commit_en), 64'(0));
      end
    end
    issue_en = 1'b0; wb_en = 1'b0;
    tick();
    check("t6_drained", 64'(commit_en), 64'(0));
    check("t6_tail_final", 64'(tail_id), 64'(4));

    // Reset mid-stream
    issue_en = 1'b1; issue_reg = 5'd3;
    tick(); tick();
    issue_en = 1'b0;
    wb_en = 1'b1; wb_id = 3'd4; wb_value = 32'h55; wb_mispredict = 1'b0;
    tick();
    wb_en = 1'b0;
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    q1_id = 3'd4;
    #1;
    check("t7_commit_en", 64'(commit_en), 64'(0));
    check("t7_commit_reg", 64'(commit_reg), 64'(0));
    check("t7_commit_id", 64'(commit_id), 64'(0));
    check("t7_commit_value", 64'(commit_value), 64'(0));
    check("t7_flush_pc", 64'(flush_pc), 64'(0));
    check("t7_tail_id", 64'(tail_id), 64'(0));
    check("t7_entry_gone", 64'(q1_ready), 64'(0));
    tick();
    check("t7_no_stale_commit", 64'(commit_en), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
